// File: rtl/mvm_pkg.sv
// Shared MVM types and sizing: state enum, result vector type, address helpers.
package mvm_pkg;

  localparam int unsigned N_ROW     = 4;
  localparam int unsigned N_COL     = 4;
  localparam int unsigned WW        = 4;
  localparam int unsigned RW        = 4;
  localparam int unsigned MAX_TILES = 256;
  localparam int unsigned TIMEOUT   = 64;

  localparam int unsigned NW  = N_ROW * N_COL;
  localparam int unsigned WAW = $clog2(MAX_TILES * N_ROW * N_COL);
  localparam int unsigned RAW = $clog2(MAX_TILES * N_ROW);
  localparam int unsigned TW  = $clog2(MAX_TILES + 1);
  localparam int unsigned KW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned RIW = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_STREAM,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  typedef logic [N_ROW-1:0][RW-1:0] wx_vec_t;

  // First weight address of a tile.
  function automatic logic [WAW-1:0] w_base(input logic [TW-1:0] tile);
    return WAW'(32'(tile) * NW);
  endfunction

  // First result address of a tile.
  function automatic logic [RAW-1:0] r_base(input logic [TW-1:0] tile);
    return RAW'(32'(tile) * N_ROW);
  endfunction

endpackage

// File: rtl/mvm_sched_drain.sv
// Latches one MVM result vector and serializes it to the result buffer over valid/ready.
module mvm_sched_drain
  import mvm_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_latch,
  input  wx_vec_t        i_vec,
  input  logic [TW-1:0]  i_tile,
  input  logic           i_res_ready,
  output logic           o_res_valid,
  output logic [RAW-1:0] o_res_addr,
  output logic [RW-1:0]  o_res_data,
  output logic           o_drain_done_c
);

  wx_vec_t        r_vec;
  logic [RIW-1:0] r_row;
  logic           r_valid;
  logic [RAW-1:0] r_addr;
  logic [RW-1:0]  r_data;

  logic           w_accept;
  logic           w_last;
  logic [RIW-1:0] w_row_nxt;

  assign w_accept       = r_valid & i_res_ready;
  assign w_last         = (r_row == RIW'(N_ROW - 1));
  assign w_row_nxt      = r_row + 1'b1;
  assign o_drain_done_c = w_accept & w_last;

  // Element 0 is presented straight from the input so valid rises with the latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vec   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_latch) begin
      r_vec   <= i_vec;
      r_row   <= '0;
      r_valid <= 1'b1;
      r_addr  <= r_base(i_tile);
      r_data  <= i_vec[0];
    end else if (w_accept) begin
      if (w_last) begin
        r_row   <= '0;
        r_valid <= 1'b0;
        r_addr  <= '0;
        r_data  <= '0;
      end else begin
        r_row  <= w_row_nxt;
        r_addr <= r_addr + 1'b1;
        r_data <= r_vec[w_row_nxt];
      end
    end
  end

  assign o_res_valid = r_valid;
  assign o_res_addr  = r_addr;
  assign o_res_data  = r_data;

endmodule

// File: rtl/mvm_sched.sv
// Layer scheduler for one MVM: per tile fetch/stream weights, wait for compute, drain results.
// Optional WAIT watchdog with sticky o_err when MVM_SCHED_TIMEOUT_EN is defined.
module mvm_sched
  import mvm_pkg::*;
(
  input  logic           i_clk_sched,
  input  logic           i_rst_sched,
  input  logic           i_start_sched,
  input  logic [TW-1:0]  i_ntiles,
  output logic [WAW-1:0] o_waddr,
  output logic           o_wren,
  input  logic [WW-1:0]  i_wdata,
  output logic           o_start_mvm,
  output logic [WW-1:0]  o_w_mvm,
  input  logic           i_ismvm,
  input  wx_vec_t        i_wx_result,
  output logic           o_res_valid,
  input  logic           i_res_ready,
  output logic [RAW-1:0] o_res_addr,
  output logic [RW-1:0]  o_res_data,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  sched_state_e   r_state, w_state_nxt;
  logic [TW-1:0]  r_ntiles, w_ntiles_nxt;
  logic [TW-1:0]  r_tile, w_tile_nxt;
  logic [KW-1:0]  r_k, w_k_nxt;
  logic [KW-1:0]  r_woff, w_woff_nxt;
  logic           r_seen, w_seen_nxt;
  logic [WAW-1:0] r_waddr, w_waddr_nxt;
  logic           r_wren;
  logic           r_start_mvm;
  logic [WW-1:0]  r_w_mvm;
  logic           r_busy;
  logic           r_done;
  logic           w_issue;
  logic           w_latch_c;
  logic           w_drain_done_c;
  logic           w_mvm_done;
`ifdef MVM_SCHED_TIMEOUT_EN
  logic [CW-1:0]  r_wcnt, w_wcnt_nxt;
  logic           r_err, w_err_nxt;
`endif

  // Completion needs a busy sighting first so a slow-to-rise MVM is not mistaken for done.
  assign w_mvm_done = r_seen & ~i_ismvm;

  always_comb begin
    w_state_nxt  = r_state;
    w_ntiles_nxt = r_ntiles;
    w_tile_nxt   = r_tile;
    w_k_nxt      = r_k;
    w_woff_nxt   = r_woff;
    w_seen_nxt   = r_seen;
    w_waddr_nxt  = '0;
    w_issue      = 1'b0;
    w_latch_c    = 1'b0;
`ifdef MVM_SCHED_TIMEOUT_EN
    w_wcnt_nxt   = r_wcnt;
    w_err_nxt    = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start_sched) begin
          w_ntiles_nxt = i_ntiles;
          w_tile_nxt   = '0;
          w_state_nxt  = (i_ntiles == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        w_k_nxt     = '0;
        w_state_nxt = S_START;
      end
      S_START: begin
        w_k_nxt     = '0;
        w_seen_nxt  = r_seen | i_ismvm;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_seen_nxt = r_seen | i_ismvm;
        if (r_k == KW'(NW - 1)) begin
          w_state_nxt = S_WAIT;
`ifdef MVM_SCHED_TIMEOUT_EN
          w_wcnt_nxt  = '0;
`endif
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_WAIT: begin
        w_seen_nxt = r_seen | i_ismvm;
        if (w_mvm_done) begin
          w_latch_c   = 1'b1;
          w_state_nxt = S_DRAIN;
        end
`ifdef MVM_SCHED_TIMEOUT_EN
        else if (r_wcnt == CW'(TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (w_drain_done_c) begin
          if (r_tile == r_ntiles - TW'(1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_tile_nxt  = r_tile + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Weight reads: base in FETCH, base+1 in START, then one per STREAM cycle until the last offset.
    w_issue = (w_state_nxt == S_FETCH) || (w_state_nxt == S_START) ||
              ((w_state_nxt == S_STREAM) && (r_woff != KW'(NW - 1)));
    if (w_state_nxt == S_FETCH) begin
      w_woff_nxt = '0;
      w_seen_nxt = 1'b0;
    end else if (w_issue) begin
      w_woff_nxt = r_woff + 1'b1;
    end
    if (w_issue) begin
      w_waddr_nxt = w_base(w_tile_nxt) + WAW'(w_woff_nxt);
    end
  end

  always_ff @(posedge i_clk_sched) begin
    if (i_rst_sched) begin
      r_state     <= S_IDLE;
      r_ntiles    <= '0;
      r_tile      <= '0;
      r_k         <= '0;
      r_woff      <= '0;
      r_seen      <= 1'b0;
      r_waddr     <= '0;
      r_wren      <= 1'b0;
      r_start_mvm <= 1'b0;
      r_w_mvm     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef MVM_SCHED_TIMEOUT_EN
      r_wcnt      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ntiles    <= w_ntiles_nxt;
      r_tile      <= w_tile_nxt;
      r_k         <= w_k_nxt;
      r_woff      <= w_woff_nxt;
      r_seen      <= w_seen_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wren      <= w_issue;
      r_start_mvm <= (w_state_nxt == S_START);
      r_w_mvm     <= (w_state_nxt == S_STREAM) ? i_wdata : '0;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
`ifdef MVM_SCHED_TIMEOUT_EN
      r_wcnt      <= w_wcnt_nxt;
      r_err       <= w_err_nxt;
`endif
    end
  end

  mvm_sched_drain u_drain (
    .i_clk          (i_clk_sched),
    .i_rst          (i_rst_sched),
    .i_latch        (w_latch_c),
    .i_vec          (i_wx_result),
    .i_tile         (r_tile),
    .i_res_ready    (i_res_ready),
    .o_res_valid    (o_res_valid),
    .o_res_addr     (o_res_addr),
    .o_res_data     (o_res_data),
    .o_drain_done_c (w_drain_done_c)
  );

  assign o_waddr     = r_waddr;
  assign o_wren      = r_wren;
  assign o_start_mvm = r_start_mvm;
  assign o_w_mvm     = r_w_mvm;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
`ifdef MVM_SCHED_TIMEOUT_EN
  assign o_err       = r_err;
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_sched.sv
// Scoreboard bench for mvm_sched: weight RAM and MVM models push expected weights/results at each start pulse.
module tb_mvm_sched;
  import mvm_pkg::*;

  localparam int OW = WAW + RAW + WW + RW + 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [TW-1:0]  ntiles = '0;
  logic [WAW-1:0] waddr;
  logic           wren;
  logic [WW-1:0]  wdata = '0;
  logic           start_mvm;
  logic [WW-1:0]  w_mvm;
  logic           ismvm = 1'b0;
  wx_vec_t        wx = '0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [RAW-1:0] res_addr;
  logic [RW-1:0]  res_data;
  logic           busy, done, err;
  logic [OW-1:0]  all_out;

  int n_vec = 0;
  int n_err = 0;

  logic [WW-1:0]  mem [0:(1<<WAW)-1];
  logic [WW-1:0]  q_w[$];
  logic [RAW-1:0] q_addr[$];
  logic [RW-1:0]  q_data[$];

  int busy_len = 20;
  bit busy_hold = 1'b0;
  int busy_cnt = 0;
  int layer_starts = 0;
  int cnt_start = 0, cnt_done = 0, cnt_wren = 0, cnt_res = 0, cnt_stall = 0;
  int ready_mode = 0, ready_ph = 0;
  int w_left = 0;
  bit p_stall = 1'b0;
  logic [RAW-1:0] p_addr;
  logic [RW-1:0]  p_data;

  always #5 clk = ~clk;

  mvm_sched u_dut (
    .i_clk_sched   (clk),
    .i_rst_sched   (rst),
    .i_start_sched (start),
    .i_ntiles      (ntiles),
    .o_waddr       (waddr),
    .o_wren        (wren),
    .i_wdata       (wdata),
    .o_start_mvm   (start_mvm),
    .o_w_mvm       (w_mvm),
    .i_ismvm       (ismvm),
    .i_wx_result   (wx),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_addr    (res_addr),
    .o_res_data    (res_data),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err)
  );

  assign all_out = {waddr, wren, start_mvm, w_mvm, res_valid, res_addr, res_data, busy, done, err};

  function automatic logic [RW-1:0] model_res(input int tile, input int row);
    return RW'(tile * 3 + row * 5 + 1);
  endfunction

  // Synchronous weight RAM: data one cycle after the read enable.
  always @(posedge clk) if (wren) wdata <= mem[waddr];

  // MVM model: busy for busy_len cycles after each start pulse; expectations queued here.
  always @(posedge clk) begin
    if (rst) begin
      ismvm    <= 1'b0;
      busy_cnt = 0;
    end else if (start_mvm) begin
      ismvm    <= 1'b1;
      busy_cnt = busy_len;
      for (int r = 0; r < N_ROW; r++) begin
        wx[r] <= model_res(layer_starts, r);
        q_addr.push_back(RAW'(layer_starts * N_ROW + r));
        q_data.push_back(model_res(layer_starts, r));
      end
      for (int k = 0; k < NW; k++) q_w.push_back(mem[WAW'(layer_starts * NW + k)]);
      layer_starts++;
    end else if (!busy_hold && busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) ismvm <= 1'b0;
    end
  end

  // Monitor: weight stream, result scoreboard, hold-while-stalled, ready pattern.
  always @(negedge clk) begin
    logic [WW-1:0] ew;
    logic [RAW-1:0] ea;
    logic [RW-1:0] ed;
    if (rst) begin
      w_left  = 0;
      p_stall = 1'b0;
    end else begin
      if (start_mvm) cnt_start++;
      if (done) cnt_done++;
      if (wren) cnt_wren++;
      if (w_left > 0) begin
        n_vec++;
        w_left--;
        if (q_w.size() == 0) begin
          n_err++;
          $display("FAIL weight_extra o_w_mvm=%0d with no expected weight", w_mvm);
        end else begin
          ew = q_w.pop_front();
          if (w_mvm !== ew) begin
            n_err++;
            $display("FAIL weight_stream o_w_mvm=%0d expected=%0d", w_mvm, ew);
          end
        end
      end else if (w_mvm !== '0) begin
        n_vec++;
        n_err++;
        $display("FAIL weight_idle o_w_mvm=%0d expected=0", w_mvm);
      end
      if (start_mvm) w_left = NW;
      if (p_stall) begin
        n_vec++;
        if (res_valid !== 1'b1 || res_addr !== p_addr || res_data !== p_data) begin
          n_err++;
          $display("FAIL stall_hold valid=%0b addr=%0d data=%0d expected valid=1 addr=%0d data=%0d",
                   res_valid, res_addr, res_data, p_addr, p_data);
        end
      end
      if (ready_mode == 0) res_ready = 1'b1;
      else if (res_valid) begin
        ready_ph  = (ready_ph + 1) % 3;
        res_ready = (ready_ph == 2);
      end
      if (res_valid && res_ready) begin
        n_vec++;
        cnt_res++;
        if (q_addr.size() == 0) begin
          n_err++;
          $display("FAIL result_extra addr=%0d data=%0d with no expected result", res_addr, res_data);
        end else begin
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          if (res_addr !== ea || res_data !== ed) begin
            n_err++;
            $display("FAIL result addr=%0d data=%0d expected addr=%0d data=%0d", res_addr, res_data, ea, ed);
          end
        end
      end
      p_stall = res_valid && !res_ready;
      p_addr  = res_addr;
      p_data  = res_data;
      if (p_stall) cnt_stall++;
    end
  end

  task automatic clear_sb();
    q_w.delete();
    q_addr.delete();
    q_data.delete();
    layer_starts = 0;
    cnt_start = 0; cnt_done = 0; cnt_wren = 0; cnt_res = 0; cnt_stall = 0;
  endtask

  task automatic start_layer(input int nt);
    @(negedge clk);
    ntiles = TW'(nt);
    start  = 1'b1;
  endtask

  // Cycle 1 is the first cycle after the edge that sampled start; -1 when the bound expires.
  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h expected=0", all_out);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL idle_outputs got=%h expected=0", all_out);
    end
  endtask

  task automatic test_single();
    int cyc;
    for (int a = 0; a < (1 << WAW); a++) mem[a] = WW'(8);
    clear_sb();
    busy_len = 20;
    start_layer(1);
    wait_done(200, cyc);
    n_vec++;
    if (cyc != 28) begin
      n_err++;
      $display("FAIL single_latency done_cycle=%0d expected=28", cyc);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_at_done busy=%0b expected=1", busy);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL single_after_done busy=%0b done=%0b expected 0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (cnt_start != 1 || cnt_done != 1 || cnt_res != 4 || cnt_wren != NW) begin
      n_err++;
      $display("FAIL single_counts starts=%0d dones=%0d results=%0d reads=%0d expected 1 1 4 %0d",
               cnt_start, cnt_done, cnt_res, cnt_wren, NW);
    end
    n_vec++;
    if (q_w.size() != 0 || q_addr.size() != 0) begin
      n_err++;
      $display("FAIL single_leftover weights=%0d results=%0d expected 0 0", q_w.size(), q_addr.size());
    end
  endtask

  task automatic test_multi();
    int cyc;
    for (int a = 0; a < (1 << WAW); a++) mem[a] = WW'(a);
    clear_sb();
    busy_len = 20;
    start_layer(3);
    wait_done(400, cyc);
    n_vec++;
    if (cyc != 82) begin
      n_err++;
      $display("FAIL multi_latency done_cycle=%0d expected=82", cyc);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (cnt_start != 3 || cnt_res != 12 || cnt_done != 1) begin
      n_err++;
      $display("FAIL multi_counts starts=%0d results=%0d dones=%0d expected 3 12 1", cnt_start, cnt_res, cnt_done);
    end
    n_vec++;
    if (q_w.size() != 0 || q_addr.size() != 0) begin
      n_err++;
      $display("FAIL multi_leftover weights=%0d results=%0d expected 0 0", q_w.size(), q_addr.size());
    end
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL multi_err o_err=%0b expected=0", err);
    end
  endtask

  task automatic test_ready_toggle();
    int cyc;
    for (int a = 0; a < (1 << WAW); a++) mem[a] = WW'($urandom_range(0, 15));
    clear_sb();
    busy_len   = 5;
    ready_ph   = 0;
    res_ready  = 1'b0;
    ready_mode = 1;
    start_layer(2);
    wait_done(400, cyc);
    n_vec++;
    if (cyc < 0) begin
      n_err++;
      $display("FAIL toggle_timeout done not seen within 400 cycles");
    end
    repeat (2) @(negedge clk);
    ready_mode = 0;
    n_vec++;
    if (cnt_res != 8 || q_addr.size() != 0 || q_w.size() != 0) begin
      n_err++;
      $display("FAIL toggle_counts results=%0d left=%0d wleft=%0d expected 8 0 0", cnt_res, q_addr.size(), q_w.size());
    end
    n_vec++;
    if (cnt_stall < 8) begin
      n_err++;
      $display("FAIL toggle_stalls stalls=%0d expected>=8", cnt_stall);
    end
  endtask

  task automatic test_zero_tiles();
    int cyc;
    clear_sb();
    start_layer(0);
    wait_done(10, cyc);
    n_vec++;
    if (cyc != 1) begin
      n_err++;
      $display("FAIL zero_latency done_cycle=%0d expected=1", cyc);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || cnt_wren != 0 || cnt_start != 0) begin
      n_err++;
      $display("FAIL zero_activity busy=%0b reads=%0d starts=%0d expected 0 0 0", busy, cnt_wren, cnt_start);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_sb();
    busy_len = 20;
    start_layer(2);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs got=%h expected=0", all_out);
    end
    @(negedge clk);
    n_vec++;
    if (cnt_done != 0) begin
      n_err++;
      $display("FAIL midreset_done dones=%0d expected=0", cnt_done);
    end
    clear_sb();
    rst = 1'b0;
    start_layer(1);
    wait_done(200, cyc);
    n_vec++;
    if (cyc != 28) begin
      n_err++;
      $display("FAIL rerun_latency done_cycle=%0d expected=28", cyc);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (cnt_start != 1 || cnt_res != 4 || q_addr.size() != 0 || q_w.size() != 0) begin
      n_err++;
      $display("FAIL rerun_counts starts=%0d results=%0d left=%0d wleft=%0d expected 1 4 0 0",
               cnt_start, cnt_res, q_addr.size(), q_w.size());
    end
  endtask

`ifdef MVM_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int hit;
    hit = -1;
    clear_sb();
    busy_hold = 1'b1;
    start_layer(1);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (err === 1'b1) begin
        hit = c;
        break;
      end
    end
    n_vec++;
    if (hit != 83 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_err err_cycle=%0d busy=%0b expected 83 0", hit, busy);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || cnt_done != 0) begin
      n_err++;
      $display("FAIL timeout_sticky err=%0b dones=%0d expected 1 0", err, cnt_done);
    end
    rst = 1'b1;
    busy_hold = 1'b0;
    repeat (2) @(negedge clk);
    clear_sb();
    rst = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_ready_toggle();
    test_zero_tiles();
    test_reset_mid();
`ifdef MVM_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
